// File: rtl/keypad_entry_if.sv
// Keypad entry bus: decoded key inputs plus entry-buffer status outputs.
// master = keypad/host side, slave = keypad_entry_ctrl.
interface keypad_entry_if #(
  parameter int NUM_DIGITS = 3
);
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    key_valid;
  logic [3:0]              key_code;
  logic [NUM_DIGITS*4-1:0] digits;
  logic [CW-1:0]           cursor;
  logic                    key_event;
  logic                    entry_done;
  logic                    timeout_clr;

  modport master (
    output key_valid, key_code,
    input  digits, cursor, key_event, entry_done, timeout_clr
  );

  modport slave (
    input  key_valid, key_code,
    output digits, cursor, key_event, entry_done, timeout_clr
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced single-action-per-press digit entry
// buffer with clear ('*'), advance ('#') and optional auto-advance.
// Optional feature macro: ENTRY_TIMEOUT_EN -- inactivity timer that clears
// a partially entered buffer after TIMEOUT_CYCLES idle cycles.
module keypad_entry_ctrl #(
  parameter int NUM_DIGITS     = 3,
  parameter bit AUTO_ADVANCE   = 1'b0,
  parameter int RELEASE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic           clk,
  input logic           rst_n,
  keypad_entry_if.slave bus
);
  localparam int            CW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DIGITS - 1);
  localparam logic [7:0]    REL_LAST = 8'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACT      = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              code_q, code_d;
  logic [7:0]              rel_cnt_q, rel_cnt_d;
  logic [NUM_DIGITS*4-1:0] digits_q, digits_d;
  logic [CW-1:0]           cursor_q, cursor_d;
  logic                    key_event_q, key_event_d;
  logic                    entry_done_q, entry_done_d;

  logic          accept_s;
  logic          wrap_s;
  logic [CW-1:0] cursor_inc_s;

  // A press is taken only when armed (IDLE) and the code is a real key.
  assign accept_s     = (state_q == IDLE) && bus.key_valid && (bus.key_code <= 4'd11);
  // Cursor advance wraps explicitly at the last slot rather than at 2^CW.
  assign wrap_s       = (cursor_q == LAST_IDX);
  assign cursor_inc_s = wrap_s ? '0 : cursor_q + 1'b1;

`ifdef ENTRY_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_clr_q, timeout_clr_d;
`endif

  // Next-state, buffer update and pulse generation.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    rel_cnt_d    = rel_cnt_q;
    digits_d     = digits_q;
    cursor_d     = cursor_q;
    key_event_d  = 1'b0;
    entry_done_d = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_clr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          code_d  = bus.key_code;
          state_d = ACT;
        end else begin
          state_d = IDLE;
        end
      end
      ACT: begin
        key_event_d = 1'b1;
        state_d     = WAIT_REL;
        rel_cnt_d   = 8'd0;
        if (code_q <= 4'd9) begin
          digits_d[{cursor_q, 2'b00} +: 4] = code_q;
          if (AUTO_ADVANCE) begin
            cursor_d     = cursor_inc_s;
            entry_done_d = wrap_s;
          end else begin
            cursor_d = cursor_q;
          end
        end else if (code_q == 4'd10) begin
          digits_d = '0;
          cursor_d = '0;
        end else begin
          cursor_d     = cursor_inc_s;
          entry_done_d = wrap_s;
        end
      end
      WAIT_REL: begin
        // Only an unbroken run of low samples re-arms the entry.
        if (bus.key_valid) begin
          rel_cnt_d = 8'd0;
        end else if (rel_cnt_q == REL_LAST) begin
          rel_cnt_d = 8'd0;
          state_d   = IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = WAIT_REL;
      end
    endcase
`ifdef ENTRY_TIMEOUT_EN
    // Accepted press reloads and so beats a simultaneous expiry.
    if (accept_s) begin
      tmo_cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        tmo_cnt_d = '0;
        if ((|digits_q) || (cursor_q != '0)) begin
          digits_d      = '0;
          cursor_d      = '0;
          timeout_clr_d = 1'b1;
        end else begin
          timeout_clr_d = 1'b0;
        end
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
`endif
  end

  // State and output registers; reset parks in WAIT_REL so a held key is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT_REL;
      code_q       <= 4'd0;
      rel_cnt_q    <= 8'd0;
      digits_q     <= '0;
      cursor_q     <= '0;
      key_event_q  <= 1'b0;
      entry_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      rel_cnt_q    <= rel_cnt_d;
      digits_q     <= digits_d;
      cursor_q     <= cursor_d;
      key_event_q  <= key_event_d;
      entry_done_q <= entry_done_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  // Inactivity timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_clr_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_clr_q <= timeout_clr_d;
    end
  end
  assign bus.timeout_clr = timeout_clr_q;
`else
  // No timer built: the comparison folds to a constant 0.
  assign bus.timeout_clr = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

  assign bus.digits     = digits_q;
  assign bus.cursor     = cursor_q;
  assign bus.key_event  = key_event_q;
  assign bus.entry_done = entry_done_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: two instances (AUTO_ADVANCE 0 and 1) share one
// key stream; an event-level model predicts outputs every cycle.
module tb_keypad_entry_ctrl;
  localparam int N   = 3;
  localparam int REL = 3;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kv;
  logic [3:0] kc;

  always #5 clk = ~clk;

  keypad_entry_if #(.NUM_DIGITS(N)) if0 ();
  keypad_entry_if #(.NUM_DIGITS(N)) if1 ();

  assign if0.key_valid = kv;
  assign if0.key_code  = kc;
  assign if1.key_valid = kv;
  assign if1.key_code  = kc;

  keypad_entry_ctrl #(.NUM_DIGITS(N), .AUTO_ADVANCE(1'b0), .RELEASE_CYCLES(REL),
                      .TIMEOUT_CYCLES(TO)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  keypad_entry_ctrl #(.NUM_DIGITS(N), .AUTO_ADVANCE(1'b1), .RELEASE_CYCLES(REL),
                      .TIMEOUT_CYCLES(TO)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int total = 0;
  int bad   = 0;

  // Model: per instance, slot values, cursor, and press-acceptance bookkeeping.
  int m_dig[2][N];
  int m_cur[2];
  bit m_armed[2];
  bit m_pend[2];
  int m_pcode[2];
  int m_low[2];
  int m_idle[2];
  bit m_ev[2], m_done[2], m_tclr[2];

  int ev_cnt[2], done_cnt[2], tclr_cnt[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_digits(input int k);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(m_dig[k][i]);
    return r;
  endfunction

  task automatic advance(input int k);
    if (m_cur[k] == N - 1) begin
      m_cur[k]  = 0;
      m_done[k] = 1'b1;
    end else begin
      m_cur[k] = m_cur[k] + 1;
    end
  endtask

  task automatic clear_buf(input int k);
    for (int i = 0; i < N; i++) m_dig[k][i] = 0;
    m_cur[k] = 0;
  endtask

  // One clock edge of the model, using inputs as sampled at that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_ev[k] = 1'b0; m_done[k] = 1'b0; m_tclr[k] = 1'b0;
      if (!rst_n) begin
        clear_buf(k);
        m_armed[k] = 1'b0; m_pend[k] = 1'b0; m_low[k] = 0; m_idle[k] = 0;
      end else if (m_pend[k]) begin
        m_pend[k] = 1'b0;
        m_low[k]  = 0;
        m_ev[k]   = 1'b1;
        if (m_pcode[k] <= 9) begin
          m_dig[k][m_cur[k]] = m_pcode[k];
          if (k == 1) advance(k);
        end else if (m_pcode[k] == 10) begin
          clear_buf(k);
        end else begin
          advance(k);
        end
      end else if (!m_armed[k]) begin
        if (kv) m_low[k] = 0;
        else    m_low[k] = m_low[k] + 1;
        if (m_low[k] == REL) begin
          m_armed[k] = 1'b1;
          m_low[k]   = 0;
        end
      end else if (kv && kc <= 4'd11) begin
        m_pend[k]  = 1'b1;
        m_pcode[k] = int'(kc);
        m_armed[k] = 1'b0;
        m_idle[k]  = 0;
      end else begin
`ifdef ENTRY_TIMEOUT_EN
        m_idle[k] = m_idle[k] + 1;
        if (m_idle[k] == TO) begin
          m_idle[k] = 0;
          if (exp_digits(k) != 12'h000 || m_cur[k] != 0) begin
            clear_buf(k);
            m_tclr[k] = 1'b1;
          end
        end
`endif
      end
    end
  endtask

  task automatic cmp_one(input int k, input logic [11:0] dg, input logic [1:0] cu,
                         input logic ev, input logic dn, input logic tc);
    chk($sformatf("dut%0d_digits", k), 32'(dg), 32'(exp_digits(k)));
    chk($sformatf("dut%0d_cursor", k), 32'(cu), 32'(m_cur[k]));
    chk($sformatf("dut%0d_key_event", k), 32'(ev), 32'(m_ev[k]));
    chk($sformatf("dut%0d_entry_done", k), 32'(dn), 32'(m_done[k]));
    chk($sformatf("dut%0d_timeout_clr", k), 32'(tc), 32'(m_tclr[k]));
    if (ev === 1'b1) ev_cnt[k]++;
    if (dn === 1'b1) done_cnt[k]++;
    if (tc === 1'b1) tclr_cnt[k]++;
  endtask

  // Advance one clock: model at the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_one(0, if0.digits, if0.cursor, if0.key_event, if0.entry_done, if0.timeout_clr);
    cmp_one(1, if1.digits, if1.cursor, if1.key_event, if1.entry_done, if1.timeout_clr);
  endtask

  task automatic idle(input int n);
    kv = 1'b0;
    repeat (n) tick();
  endtask

  // Press and hold; key_code is changed mid-hold and must not matter.
  task automatic press(input int code, input int hold);
    kv = 1'b1;
    kc = 4'(code);
    tick();
    kc = 4'(code) ^ 4'd1;
    repeat (hold - 1) tick();
    kv = 1'b0;
    kc = 4'd0;
    repeat (5) tick();
  endtask

  int e0, d0, d1, t0;
  int guard;

  initial begin
    rst_n = 1'b0; kv = 1'b0; kc = 4'd0;
    repeat (3) tick();
    chk("reset_digits", 32'(if0.digits), 32'h000);
    chk("reset_cursor", 32'(if0.cursor), 32'd0);
    chk("reset_event", 32'(if0.key_event), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Long hold gives one action; second digit overwrites slot 0.
    e0 = ev_cnt[0];
    press(5, 20);
    chk("hold_one_event", 32'(ev_cnt[0] - e0), 32'd1);
    press(7, 2);
    chk("s1_digits", 32'(if0.digits), 32'h007);
    chk("s1_cursor", 32'(if0.cursor), 32'd0);
    chk("s1_events", 32'(ev_cnt[0] - e0), 32'd2);
    chk("s1_model_aa", 32'(exp_digits(1)), 32'h075);
    press(10, 2);

    // Digit/advance sequence with wrap.
    d0 = done_cnt[0];
    press(1, 2); press(11, 2);
    chk("s2_cursor1", 32'(if0.cursor), 32'd1);
    press(2, 2); press(11, 2);
    chk("s2_cursor2", 32'(if0.cursor), 32'd2);
    press(3, 2); press(11, 2);
    chk("s2_digits", 32'(if0.digits), 32'h321);
    chk("s2_cursor0", 32'(if0.cursor), 32'd0);
    chk("s2_done", 32'(done_cnt[0] - d0), 32'd1);
    chk("s2_model_aa", 32'(exp_digits(1)), 32'h231);

    // Reset during ACT discards; key held through reset is ignored.
    e0 = ev_cnt[0];
    kv = 1'b1; kc = 4'd5;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    kc = 4'd8;
    rst_n = 1'b1;
    repeat (5) tick();
    idle(3);
    press(4, 2);
    chk("s3_digits", 32'(if0.digits), 32'h004);
    chk("s3_events", 32'(ev_cnt[0] - e0), 32'd1);

    // Release glitch: only a full run of low samples re-arms.
    press(10, 2);
    e0 = ev_cnt[0];
    kv = 1'b1; kc = 4'd2; tick();
    kv = 1'b0; tick(); tick(); tick();
    kv = 1'b1; kc = 4'd9; tick();
    kv = 1'b0; tick(); tick();
    kv = 1'b1; tick();
    kv = 1'b0; tick(); tick(); tick();
    chk("s4_no_second", 32'(ev_cnt[0] - e0), 32'd1);
    kv = 1'b1; kc = 4'd9; tick();
    idle(5);
    chk("s4_events", 32'(ev_cnt[0] - e0), 32'd2);
    chk("s4_digits", 32'(if0.digits), 32'h009);

    // Auto-advance instance: 9,8,7 then clear.
    press(10, 2);
    d1 = done_cnt[1];
    press(9, 2); press(8, 2);
    chk("s5_done_before", 32'(done_cnt[1] - d1), 32'd0);
    press(7, 2);
    chk("s5_digits", 32'(if1.digits), 32'h789);
    chk("s5_done", 32'(done_cnt[1] - d1), 32'd1);
    press(10, 2);
    chk("s5_clear", 32'(if1.digits), 32'h000);
    chk("s5_cursor", 32'(if1.cursor), 32'd0);

    // Codes 12-15 are ignored.
    e0 = ev_cnt[0];
    press(13, 3);
    press(15, 2);
    chk("s6_ignored", 32'(ev_cnt[0] - e0), 32'd0);

    // Inactivity behaviour.
    t0 = tclr_cnt[0];
    press(6, 2);
    idle(110);
`ifdef ENTRY_TIMEOUT_EN
    chk("s7_tclr", 32'(tclr_cnt[0] - t0), 32'd1);
    chk("s7_digits", 32'(if0.digits), 32'h000);
    t0 = tclr_cnt[0];
    press(3, 2);
    guard = 0;
    kv = 1'b0;
    while (m_idle[0] != TO - 1 && guard < 300) begin
      tick();
      guard++;
    end
    chk("s7_wait_bound", 32'(guard < 300), 32'd1);
    kv = 1'b1; kc = 4'd2;
    tick(); tick();
    idle(5);
    chk("s7_press_wins", 32'(tclr_cnt[0] - t0), 32'd0);
    chk("s7_press_digits", 32'(if0.digits), 32'h002);
`else
    guard = 0;
    chk("s7_no_tclr", 32'(tclr_cnt[0] - t0), 32'd0);
    chk("s7_digits_kept", 32'(if0.digits), 32'h006);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
